// File: rtl/mul_pkg.sv
// Shared encodings for the sequential radix-4 Booth multiplier:
// controller states and the Booth digit set with its window decoder.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    DIG_ZERO,
    DIG_POS1,
    DIG_POS2,
    DIG_NEG1,
    DIG_NEG2
  } digit_e;

  // Window is {Q[1], Q[0], q_m1}.
  function automatic digit_e booth_decode(input logic [2:0] win);
    digit_e dig;
    case (win)
      3'b001, 3'b010: dig = DIG_POS1;
      3'b011:         dig = DIG_POS2;
      3'b100:         dig = DIG_NEG2;
      3'b101, 3'b110: dig = DIG_NEG1;
      default:        dig = DIG_ZERO;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Combinational Booth digit stage: turns the 3-bit recoding window and the
// extended multiplicand into the signed addend for the accumulator.
module booth_r4_digit
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       window_i,
  input  logic [WIDTH+1:0] m_ext_i,
  output logic [WIDTH+2:0] addend_o
);

  localparam int AW = WIDTH + 3;

  logic [AW-1:0] m_sx;
  logic [AW-1:0] m_x2;
  digit_e        dig;

  always_comb begin
    m_sx     = {m_ext_i[WIDTH+1], m_ext_i};
    m_x2     = m_sx << 1;
    dig      = booth_decode(window_i);
    addend_o = '0;
    case (dig)
      DIG_POS1: addend_o = m_sx;
      DIG_POS2: addend_o = m_x2;
      DIG_NEG1: addend_o = ~m_sx + AW'(1);
      DIG_NEG2: addend_o = ~m_x2 + AW'(1);
      default:  addend_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_mul_seq.sv
// Sequential radix-4 Booth multiplier retiring one digit per clock;
// signed or unsigned operands, 2*WIDTH product held in HI/LO.
module booth_r4_mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] M,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int XW   = WIDTH + 2;
  localparam int AW   = WIDTH + 3;
  localparam int CW   = $clog2(ITER + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    a_q, a_d;
  logic [XW-1:0]    q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [XW-1:0]    m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [AW-1:0]    addend;
  logic [AW-1:0]    sum;
  logic [AW-1:0]    a_next;
  logic [XW-1:0]    q_next;
  logic             qm1_next;
  logic [XW-1:0]    q_ext;
  logic [XW-1:0]    m_ext;

  booth_r4_digit #(
    .WIDTH (WIDTH)
  ) u_digit (
    .window_i (({q_q[1:0], qm1_q})),
    .m_ext_i  (m_q),
    .addend_o (addend)
  );

  // One Booth step: accumulate, then arithmetic shift of {A,Q,q_m1} by two.
  always_comb begin
    sum      = a_q + addend;
    a_next   = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_next   = {sum[1:0], q_q[XW-1:2]};
    qm1_next = q_q[1];
    q_ext    = signed_op ? {{2{Q[WIDTH-1]}}, Q} : {2'b00, Q};
    m_ext    = signed_op ? {{2{M[WIDTH-1]}}, M} : {2'b00, M};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = CW'(ITER);
          a_d     = '0;
          q_d     = q_ext;
          qm1_d   = 1'b0;
          m_d     = m_ext;
        end
      end
      ST_RUN: begin
        a_d   = a_next;
        q_d   = q_next;
        qm1_d = qm1_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          // Low 2*WIDTH bits of the final {A,Q}.
          hi_d    = {a_next[WIDTH-3:0], q_next[XW-1:WIDTH]};
          lo_d    = q_next[WIDTH-1:0];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: tb/tb_booth_r4_mul_seq.sv
// Self-checking bench for booth_r4_mul_seq (WIDTH=32) against a plain
// 64-bit multiply reference.
module tb_booth_r4_mul_seq;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic        signed_op;
  logic [31:0] Q;
  logic [31:0] M;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  booth_r4_mul_seq #(
    .WIDTH (32)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .signed_op (signed_op),
    .Q         (Q),
    .M         (M),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'(int'(a));
      sb = longint'(int'(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drives one operation from a negedge; returns at the negedge where done is seen.
  task automatic run_op(input bit s, input logic [31:0] q, input logic [31:0] m,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int lat, output bit stable, output int waited);
    logic [31:0] h0, l0;
    waited = 0;
    while (ready !== 1'b1 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    signed_op = s;
    Q         = q;
    M         = m;
    start     = 1'b1;
    @(negedge clock);
    start     = 1'b0;
    Q         = $urandom;
    M         = $urandom;
    signed_op = 1'($urandom);
    h0 = HI;
    l0 = LO;
    lat = 0;
    stable = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clock);
      lat++;
      if (done !== 1'b1 && (HI !== h0 || LO !== l0)) stable = 1'b0;
    end
    hi = HI;
    lo = LO;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    start = 1'b0;
    signed_op = 1'b0;
    Q = '0;
    M = '0;
    repeat (2) @(negedge clock);
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got ready/busy/done=%b expected 100", {ready, busy, done});
    end
    checks++;
    if ({HI, LO} !== 64'd0) begin
      errors++;
      $display("FAIL reset_hilo: got %h_%h expected 0", HI, LO);
    end
    clear = 1'b0;
    @(negedge clock);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", ready);
    end
  endtask

  task automatic test_directed();
    bit          ds[5];
    logic [31:0] dq[5];
    logic [31:0] dm[5];
    logic [63:0] dexp[5];
    logic [31:0] hi, lo;
    int lat, waited;
    bit stable;
    ds   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    dq   = '{32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    dm   = '{32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0002};
    dexp = '{64'hFFFF_FFFF_FFFF_FFDD, 64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001,
             64'h4000_0000_0000_0000, 64'h0000_0001_0000_0000};
    for (int i = 0; i < 5; i++) begin
      run_op(ds[i], dq[i], dm[i], hi, lo, lat, stable, waited);
      checks++;
      if ({hi, lo} !== dexp[i]) begin
        errors++;
        $display("FAIL directed_%0d: got %h_%h expected %h", i, hi, lo, dexp[i]);
      end
      checks++;
      if (lat !== 17) begin
        errors++;
        $display("FAIL directed_latency_%0d: got %0d edges expected 17", i, lat);
      end
    end
    @(negedge clock);
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL done_one_cycle: got ready/busy/done=%b expected 100", {ready, busy, done});
    end
  endtask

  task automatic test_start_held();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    signed_op = 1'b0;
    Q = 32'd3;
    M = 32'd5;
    start = 1'b1;
    @(negedge clock);
    Q = 32'd7;
    M = 32'd9;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n !== 17) begin
      errors++;
      $display("FAIL held_latency: got %0d edges expected 17", n);
    end
    checks++;
    if ({HI, LO} !== 64'd15) begin
      errors++;
      $display("FAIL held_first_result: got %h_%h expected 15", HI, LO);
    end
    @(negedge clock);
    checks++;
    if (ready !== 1'b1 || {HI, LO} !== 64'd15) begin
      errors++;
      $display("FAIL held_idle_after_done: got ready=%b hilo=%h_%h expected ready=1 hilo=15", ready, HI, LO);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL held_second_accept: got busy=%b expected 1", busy);
    end
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if ({HI, LO} !== 64'd63) begin
      errors++;
      $display("FAIL held_second_result: got %h_%h expected 63", HI, LO);
    end
  endtask

  task automatic test_clear_mid();
    logic [31:0] hi, lo;
    int lat, waited, n;
    bit stable;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    signed_op = 1'b1;
    Q = 32'h1234_5678;
    M = 32'h9ABC_DEF0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    @(posedge clock);
    #1 clear = 1'b1;
    #1;
    checks++;
    if ({ready, busy, done} !== 3'b100 || {HI, LO} !== 64'd0) begin
      errors++;
      $display("FAIL clear_mid_run: got ready/busy/done=%b hilo=%h_%h expected 100 and 0",
               {ready, busy, done}, HI, LO);
    end
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    run_op(1'b0, 32'd3, 32'd4, hi, lo, lat, stable, waited);
    checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_000C) begin
      errors++;
      $display("FAIL clear_then_op: got %h_%h expected 0000000c", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, m, hi, lo;
    logic [63:0] exp;
    int lat, waited;
    bit s, stable;
    for (int i = 0; i < 20; i++) begin
      s = 1'($urandom);
      q = rand_operand();
      m = rand_operand();
      exp = ref_mul(s, q, m);
      run_op(s, q, m, hi, lo, lat, stable, waited);
      checks++;
      if ({hi, lo} !== exp || lat !== 17) begin
        errors++;
        $display("FAIL b2b_%0d: got %h_%h lat=%0d expected %h lat=17", i, hi, lo, lat, exp);
      end
      if (i > 0) begin
        checks++;
        if (waited !== 1) begin
          errors++;
          $display("FAIL b2b_gap_%0d: got %0d cycles after done expected 1", i, waited);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] q, m, hi, lo;
    logic [63:0] exp;
    int lat, waited;
    bit s, stable;
    for (int i = 0; i < 1500; i++) begin
      s = 1'($urandom);
      q = rand_operand();
      m = rand_operand();
      exp = ref_mul(s, q, m);
      run_op(s, q, m, hi, lo, lat, stable, waited);
      checks++;
      if ({hi, lo} !== exp) begin
        errors++;
        $display("FAIL random_%0d: s=%0d q=%h m=%h got %h_%h expected %h", i, s, q, m, hi, lo, exp);
      end
      checks++;
      if (!stable || lat !== 17) begin
        errors++;
        $display("FAIL random_run_%0d: got stable=%0d lat=%0d expected stable=1 lat=17", i, stable, lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_held();
    test_clear_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
